// File: rtl/read_miss_requester.sv
// Read-miss issue path: queue the miss address in R_MISS_FIFO, then request it from CXL.
// Optional READ_MISS_REQ_PERF_EN adds request and stall counters.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 64
`endif

module read_miss_requester #(
    parameter int ADDR_WIDTH      = `AXI_ADDR_WIDTH,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [ADDR_WIDTH-1:0] miss_addr_i,
    output logic                  fifo_write_en_o,
    input  logic                  fifo_full_i,
    output logic [ADDR_WIDTH-1:0] fifo_wdata_o,
    output logic                  cxl_ar_valid_o,
    input  logic                  cxl_ar_ready_i,
    output logic [ADDR_WIDTH-1:0] cxl_araddr_o,
    input  logic                  done_i,
    output logic [CNT_WIDTH-1:0]  outstanding_o,
`ifdef READ_MISS_REQ_PERF_EN
    output logic [31:0]           req_cnt_o,
    output logic [31:0]           stall_cnt_o,
`endif
    output logic                  idle_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUSH,
        S_REQ
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  err_q;
    logic                  accept;
    logic                  handshake;

    always_comb begin
        state_d         = state_q;
        miss_ready_o    = 1'b0;
        fifo_write_en_o = 1'b0;
        cxl_ar_valid_o  = 1'b0;
        accept          = 1'b0;
        handshake       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                miss_ready_o = (cnt_q < MAX_CNT);
                accept       = miss_valid_i && miss_ready_o;
                if (accept) state_d = S_PUSH;
            end
            S_PUSH: begin
                fifo_write_en_o = !fifo_full_i;
                if (!fifo_full_i) state_d = S_REQ;
            end
            S_REQ: begin
                cxl_ar_valid_o = 1'b1;
                handshake      = cxl_ar_ready_i;
                if (cxl_ar_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Simultaneous push and pop cancel; a pop at zero is flagged, never wrapped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) addr_q <= miss_addr_i;
            if (fifo_write_en_o && !done_i)
                cnt_q <= cnt_q + 1'b1;
            else if (!fifo_write_en_o && done_i && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            if (done_i && cnt_q == '0) err_q <= 1'b1;
        end
    end

`ifdef READ_MISS_REQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_cnt_o   <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (handshake) req_cnt_o <= req_cnt_o + 32'd1;
            if (miss_valid_i && !miss_ready_o)
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

    assign fifo_wdata_o  = addr_q;
    assign cxl_araddr_o  = addr_q;
    assign outstanding_o = cnt_q;
    assign idle_o        = (state_q == S_IDLE) && (cnt_q == '0);
    assign err_o         = err_q;

endmodule
